axis_bk_bridge: RTL and testbench
=================================

// Module: axis_bk_bridge
// PURPOSE
//  Parametrised AXI-Stream slave to backend bridge, the successor of the fixed 32-bit axis/bk interface.
//  Ingress AXIS beats are buffered in a DEPTH-entry FIFO and replayed to the backend one strobe per beat.
//  Backend paces beats with bk_nordy and acknowledges each frame (tlast) with bk_done.
//  Sits between the axilite_axis stream port and user-project backend logic.
// PARAMETERS
//  DATA_W   32  tdata/bk_data width; multiple of 8. STRB_W = DATA_W/8 (localparam)
//  USER_W   2   tuser/bk_user width, >=1
//  DEPTH    8   FIFO entries; power of 2, >=2
//  DONE_TO  0   max cycles waiting for bk_done; 0 = wait forever
// PORTS
//  axi_aclk      in   1         clock
//  axi_areset    in   1         reset, asynchronous, active-high
//  axis_tvalid   in   1         ingress beat valid
//  axis_tdata    in   DATA_W    ingress data
//  axis_tstrb    in   STRB_W    ingress byte strobes
//  axis_tkeep    in   STRB_W    ingress byte keeps
//  axis_tlast    in   1         last beat of frame
//  axis_tuser    in   USER_W    ingress sideband
//  axis_tready   out  1         ingress ready
//  bk_start      out  1         1-cycle strobe: bk_* beat valid this cycle
//  bk_data/bk_tstrb/bk_tkeep/bk_user  out  DATA_W/STRB_W/STRB_W/USER_W  beat payload
//  bk_last       out  1         beat is last of frame
//  bk_nordy      in   1         backend not ready: stalls next beat
//  bk_done       in   1         backend frame acknowledge
//  fifo_level    out  $clog2(DEPTH)+1  entries currently stored
//  err_timeout   out  1         sticky: DONE_TO exceeded
//  stat_beats    out  32        beats delivered to backend
//  stat_frames   out  32        frames acknowledged
// BEHAVIOUR
//  Reset: FIFO emptied, FSM=IDLE, all outputs 0 (axis_tready 0 while axi_areset high, then 1 once released).
//  Reset mid-frame: buffered and partial frames are discarded; no bk_start after reset release until a new push.
//  Ingress: axis_tready = !full; push on tvalid&&tready, storing {data,strb,keep,user,last}.
//  Full: tready=0, no push; FIFO never overwrites. No empty bypass: latency push cycle n -> bk_start in cycle n+2 minimum.
//  Egress FSM (bk_* registered):
//   IDLE/XFER: if !empty && !bk_nordy: pop head, drive bk_* next cycle with bk_start=1; bk_* hold last value when bk_start=0.
//    Popped beat with last=1 -> WAIT_DONE; else remain XFER (IDLE if FIFO empties between frames).
//    bk_nordy sampled one cycle ahead: bk_nordy high in cycle t blocks bk_start in t+1.
//   WAIT_DONE: no pops; on bk_done=1 -> IDLE, stat_frames+1. Simultaneous bk_nordy ignored for exit.
//    DONE_TO>0: counter increments each WAIT_DONE cycle; on reaching DONE_TO set err_timeout, force -> IDLE.
//  bk_done outside WAIT_DONE: ignored.
//  Push and pop same cycle: level unchanged; pop at empty never occurs.
//  Pointers wrap modulo DEPTH; level counts 0..DEPTH.
//  err_timeout is cleared only by reset.
// CONFIGURATION
//  AXIS_BK_STATS_EN defined:
//   stat_beats increments on each bk_start; stat_frames increments on each bk_done exit. Both wrap 2^32-1 -> 0.
//  Macro undefined: stat_* ports present but tied to 0; counters not synthesised.
// STRUCTURE
//  Package axis_bk_pkg: typedef enum {IDLE,XFER,WAIT_DONE} bk_state_e; packed beat struct builder;
//   localparams for STRB_W and level width.
//  Sub-module axis_bk_fifo: sync FIFO with DEPTH, WIDTH params; outputs full/empty/level; async reset.
// TESTING
//  1 beat, tlast=1, data 0xA5A5_0001, bk_nordy=0 -> bk_start cycle n+2, bk_last=1; FIFO waits for bk_done;
//   bk_done -> IDLE, stat_frames=1.
//  DEPTH=8, bk_nordy=1, push 9 beats -> tready drops after 8th, fifo_level=8; release -> beats 0..7 in order.
//  4-beat frame then 2-beat frame, bk_done withheld -> exactly 4 strobes, 2 held;
//   bk_done -> 2 more strobes.
//  DONE_TO=16, frame sent, no bk_done -> err_timeout=1 after 16 WAIT_DONE cycles; next frame still delivered.
//  Reset asserted with 3 beats buffered mid-frame -> level=0, no bk_start, outputs 0; post-reset frame is clean.
//  DATA_W=64, USER_W=4, tkeep=0x0F, tuser=0xA -> bk_tkeep=0x0F, bk_user=0xA;
//   with AXIS_BK_STATS_EN, stat_beats counts each beat.

Source files
------------

// File: rtl/axis_bk_pkg.sv
// Shared types and width helpers for the AXI-Stream to backend bridge.
package axis_bk_pkg;

   typedef enum logic [1:0] {IDLE, XFER, WAIT_DONE} bk_state_e;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_STRB_W = DEF_DATA_W / 8;

   function automatic int strb_w(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Packed beat layout, MSB first: {data, strb, keep, user, last}
   function automatic int beat_w(input int data_w, input int user_w);
      return data_w + 2 * (data_w / 8) + user_w + 1;
   endfunction

endpackage

// File: rtl/axis_bk_fifo.sv
// Synchronous FIFO with occupancy level; pointers wrap modulo DEPTH (power of 2).
module axis_bk_fifo #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_level
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_level;
   logic             w_wr;
   logic             w_rd;

   assign w_wr    = i_push && !o_full;
   assign w_rd    = i_pop && !o_empty;
   assign o_full  = (r_level == (AW + 1)'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_rdata = r_mem[r_rptr];

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wptr] <= i_wdata;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) r_rptr <= r_rptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/axis_bk_bridge.sv
// AXI-Stream slave to backend bridge: FIFO-buffered beats replayed one strobe per beat.
// Optional statistics counters are built when AXIS_BK_STATS_EN is defined.
module axis_bk_bridge
   import axis_bk_pkg::*;
#(
   parameter  int DATA_W  = 32,
   parameter  int USER_W  = 2,
   parameter  int DEPTH   = 8,
   parameter  int DONE_TO = 0,
   localparam int STRB_W  = strb_w(DATA_W),
   localparam int LVL_W   = lvl_w(DEPTH)
) (
   input  logic              axi_aclk,
   input  logic              axi_areset,
   input  logic              axis_tvalid,
   input  logic [DATA_W-1:0] axis_tdata,
   input  logic [STRB_W-1:0] axis_tstrb,
   input  logic [STRB_W-1:0] axis_tkeep,
   input  logic              axis_tlast,
   input  logic [USER_W-1:0] axis_tuser,
   output logic              axis_tready,
   output logic              bk_start,
   output logic [DATA_W-1:0] bk_data,
   output logic [STRB_W-1:0] bk_tstrb,
   output logic [STRB_W-1:0] bk_tkeep,
   output logic [USER_W-1:0] bk_user,
   output logic              bk_last,
   input  logic              bk_nordy,
   input  logic              bk_done,
   output logic [LVL_W-1:0]  fifo_level,
   output logic              err_timeout,
   output logic [31:0]       stat_beats,
   output logic [31:0]       stat_frames
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
      logic [STRB_W-1:0] keep;
      logic [USER_W-1:0] user;
      logic              last;
   } beat_t;

   localparam logic [31:0] TO_LAST = (DONE_TO > 0) ? 32'(DONE_TO - 1) : 32'd0;

   bk_state_e r_state, w_next;
   beat_t     w_in, w_head, r_out;
   logic      w_full, w_empty, w_pop, w_timeout;
   logic      r_start, r_err;
   logic [31:0] r_to_cnt;

   assign w_in        = {axis_tdata, axis_tstrb, axis_tkeep, axis_tuser, axis_tlast};
   assign axis_tready = !w_full && !axi_areset;

   axis_bk_fifo #(.DEPTH(DEPTH), .WIDTH($bits(beat_t))) u_fifo (
      .i_clk   (axi_aclk),
      .i_rst   (axi_areset),
      .i_push  (axis_tvalid && axis_tready),
      .i_wdata (w_in),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (fifo_level)
   );

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) r_state <= IDLE;
      else            r_state <= w_next;
   end

   // bk_nordy is looked at in the pop cycle, so it gates the strobe one cycle later
   always_comb begin
      w_next    = r_state;
      w_pop     = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         IDLE, XFER: begin
            if (!w_empty && !bk_nordy) begin
               w_pop  = 1'b1;
               w_next = w_head.last ? WAIT_DONE : XFER;
            end else if (w_empty) begin
               w_next = IDLE;
            end
         end
         WAIT_DONE: begin
            if (bk_done) begin
               w_next = IDLE;
            end else if ((DONE_TO > 0) && (r_to_cnt == TO_LAST)) begin
               w_next    = IDLE;
               w_timeout = 1'b1;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         r_start  <= 1'b0;
         r_out    <= '0;
         r_to_cnt <= '0;
         r_err    <= 1'b0;
      end else begin
         r_start <= w_pop;
         if (w_pop) r_out <= w_head;
         r_to_cnt <= (r_state == WAIT_DONE) ? r_to_cnt + 32'd1 : 32'd0;
         if (w_timeout) r_err <= 1'b1;
      end
   end

   assign bk_start    = r_start;
   assign bk_data     = r_out.data;
   assign bk_tstrb    = r_out.strb;
   assign bk_tkeep    = r_out.keep;
   assign bk_user     = r_out.user;
   assign bk_last     = r_out.last;
   assign err_timeout = r_err;

`ifdef AXIS_BK_STATS_EN
   logic [31:0] r_stat_beats, r_stat_frames;

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         r_stat_beats  <= '0;
         r_stat_frames <= '0;
      end else begin
         if (w_pop) r_stat_beats <= r_stat_beats + 32'd1;
         if ((r_state == WAIT_DONE) && bk_done) r_stat_frames <= r_stat_frames + 32'd1;
      end
   end

   assign stat_beats  = r_stat_beats;
   assign stat_frames = r_stat_frames;
`else
   assign stat_beats  = '0;
   assign stat_frames = '0;
`endif

endmodule

// File: tb/tb_axis_bk_bridge.sv
// Scoreboard bench for axis_bk_bridge (DATA_W=64, USER_W=4, DEPTH=8, DONE_TO=16).
module tb_axis_bk_bridge;

   localparam int DATA_W  = 64;
   localparam int USER_W  = 4;
   localparam int DEPTH   = 8;
   localparam int DONE_TO = 16;
   localparam int STRB_W  = DATA_W / 8;
   localparam int LVL_W   = $clog2(DEPTH) + 1;
   localparam int BEAT_W  = DATA_W + 2 * STRB_W + USER_W + 1;

   typedef logic [BEAT_W-1:0] beat_t;

   logic              clk = 1'b0;
   logic              axi_areset = 1'b1;
   logic              axis_tvalid = 1'b0;
   logic [DATA_W-1:0] axis_tdata = '0;
   logic [STRB_W-1:0] axis_tstrb = '0;
   logic [STRB_W-1:0] axis_tkeep = '0;
   logic              axis_tlast = 1'b0;
   logic [USER_W-1:0] axis_tuser = '0;
   logic              axis_tready;
   logic              bk_start;
   logic [DATA_W-1:0] bk_data;
   logic [STRB_W-1:0] bk_tstrb;
   logic [STRB_W-1:0] bk_tkeep;
   logic [USER_W-1:0] bk_user;
   logic              bk_last;
   logic              bk_nordy = 1'b0;
   logic              bk_done = 1'b0;
   logic [LVL_W-1:0]  fifo_level;
   logic              err_timeout;
   logic [31:0]       stat_beats;
   logic [31:0]       stat_frames;

   beat_t q[$];
   int n_chk = 0, n_fail = 0, n_start = 0, base_start = 0, exp_frames = 0, s0 = 0;

   always #5 clk = ~clk;

   axis_bk_bridge #(.DATA_W(DATA_W), .USER_W(USER_W), .DEPTH(DEPTH), .DONE_TO(DONE_TO)) dut (
      .axi_aclk    (clk),
      .axi_areset  (axi_areset),
      .axis_tvalid (axis_tvalid),
      .axis_tdata  (axis_tdata),
      .axis_tstrb  (axis_tstrb),
      .axis_tkeep  (axis_tkeep),
      .axis_tlast  (axis_tlast),
      .axis_tuser  (axis_tuser),
      .axis_tready (axis_tready),
      .bk_start    (bk_start),
      .bk_data     (bk_data),
      .bk_tstrb    (bk_tstrb),
      .bk_tkeep    (bk_tkeep),
      .bk_user     (bk_user),
      .bk_last     (bk_last),
      .bk_nordy    (bk_nordy),
      .bk_done     (bk_done),
      .fifo_level  (fifo_level),
      .err_timeout (err_timeout),
      .stat_beats  (stat_beats),
      .stat_frames (stat_frames)
   );

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_stat(input int v);
`ifdef AXIS_BK_STATS_EN
      return 32'(v);
`else
      return (v == v) ? 32'd0 : 32'd1;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s,
                            input logic [STRB_W-1:0] k, input logic [USER_W-1:0] u, input logic l);
      bit ok;
      bit acc;
      acc = 1'b0;
      axis_tvalid = 1'b1;
      axis_tdata  = d;
      axis_tstrb  = s;
      axis_tkeep  = k;
      axis_tuser  = u;
      axis_tlast  = l;
      for (int i = 0; i < 100; i++) begin
         ok = axis_tready;
         tick();
         if (ok) begin
            q.push_back({d, s, k, u, l});
            acc = 1'b1;
            break;
         end
      end
      axis_tvalid = 1'b0;
      check_eq("push_accept", acc, 1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100; i++) begin
         if (q.size() == 0) break;
         tick();
      end
      check_eq("drain", q.size(), 0);
   endtask

   task automatic pulse_done();
      bk_done = 1'b1;
      tick();
      bk_done = 1'b0;
   endtask

   always @(negedge clk) begin
      beat_t e;
      if (!axi_areset && bk_start) begin
         n_start++;
         check_eq("sb_nonempty", q.size() != 0, 1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check_eq("beat", {bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last}, e);
         end
      end
   end

   initial begin
      #3;
      check_eq("rst_tready", axis_tready, 0);
      check_eq("rst_start", bk_start, 0);
      check_eq("rst_level", fifo_level, 0);
      check_eq("rst_data", bk_data, 0);
      check_eq("rst_err", err_timeout, 0);
      check_eq("rst_beats", stat_beats, 0);
      tick();
      tick();
      axi_areset = 1'b0;
      tick();
      check_eq("post_rst_tready", axis_tready, 1);

      // Single-beat frame: latency and wait for acknowledge
      s0 = n_start;
      push_beat(64'hA5A5_0001, 8'hFF, 8'hFF, 4'h1, 1'b1);
      check_eq("lat_n1", bk_start, 0);
      tick();
      check_eq("lat_n2", bk_start, 1);
      check_eq("lat_last", bk_last, 1);
      push_beat(64'hA5A5_0002, 8'hFF, 8'hFF, 4'h2, 1'b1);
      repeat (4) tick();
      check_eq("held_strobes", n_start - s0, 1);
      check_eq("held_level", fifo_level, 1);
      pulse_done();
      exp_frames++;
      wait_drain();
      check_eq("after_done_strobes", n_start - s0, 2);
      check_eq("frames1", stat_frames, exp_stat(exp_frames));
      pulse_done();
      exp_frames++;
      pulse_done();
      tick();
      check_eq("done_in_idle", stat_frames, exp_stat(exp_frames));

      // Fill to DEPTH with backend stalled
      s0 = n_start;
      bk_nordy = 1'b1;
      for (int i = 0; i < DEPTH; i++)
         push_beat(64'h1000 + 64'(i), 8'hFF, 8'h3C, 4'(i), 1'b0);
      check_eq("full_level", fifo_level, DEPTH);
      axis_tvalid = 1'b1;
      axis_tdata  = 64'h1008;
      tick();
      check_eq("full_tready", axis_tready, 0);
      tick();
      check_eq("full_hold", fifo_level, DEPTH);
      check_eq("full_nostart", n_start - s0, 0);
      bk_nordy = 1'b0;
      push_beat(64'h1008, 8'hFF, 8'h3C, 4'h8, 1'b1);
      wait_drain();
      check_eq("full_strobes", n_start - s0, DEPTH + 1);
      pulse_done();
      exp_frames++;

      // Two frames back to back, acknowledge withheld
      s0 = n_start;
      for (int i = 0; i < 6; i++)
         push_beat(64'h3000 + 64'($urandom_range(0, 255)), 8'hF0, 8'hFF, 4'(i), (i == 3) || (i == 5));
      repeat (4) tick();
      check_eq("two_frame_strobes", n_start - s0, 4);
      check_eq("two_frame_level", fifo_level, 2);
      pulse_done();
      exp_frames++;
      wait_drain();
      check_eq("two_frame_rest", n_start - s0, 6);
      pulse_done();
      exp_frames++;

      // Acknowledge timeout
      push_beat(64'h4444, 8'h01, 8'h01, 4'h4, 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bk_start) break;
      end
      check_eq("to_seen", bk_start, 1);
      repeat (DONE_TO - 1) tick();
      check_eq("to_before", err_timeout, 0);
      tick();
      check_eq("to_after", err_timeout, 1);
      push_beat(64'h4445, 8'h02, 8'h02, 4'h5, 1'b1);
      wait_drain();
      check_eq("to_sticky", err_timeout, 1);
      check_eq("to_frames", stat_frames, exp_stat(exp_frames));
      pulse_done();
      exp_frames++;

      // Reset with a partial frame buffered
      bk_nordy = 1'b1;
      for (int i = 0; i < 3; i++)
         push_beat(64'h5000 + 64'(i), 8'hFF, 8'hFF, 4'h5, 1'b0);
      check_eq("mid_level", fifo_level, 3);
      axi_areset = 1'b1;
      q.delete();
      #1;
      check_eq("mid_rst_level", fifo_level, 0);
      check_eq("mid_rst_start", bk_start, 0);
      check_eq("mid_rst_data", bk_data, 0);
      check_eq("mid_rst_last", bk_last, 0);
      check_eq("mid_rst_err", err_timeout, 0);
      check_eq("mid_rst_tready", axis_tready, 0);
      check_eq("mid_rst_frames", stat_frames, 0);
      tick();
      tick();
      axi_areset = 1'b0;
      bk_nordy   = 1'b0;
      exp_frames = 0;
      base_start = n_start;
      repeat (6) tick();
      check_eq("no_start_after_rst", n_start - base_start, 0);
      check_eq("tready_after_rst", axis_tready, 1);
      push_beat(64'hDEAD_BEEF_0000_0001, 8'hFF, 8'h0F, 4'hA, 1'b0);
      push_beat(64'hDEAD_BEEF_0000_0002, 8'h0F, 8'h0F, 4'hA, 1'b1);
      wait_drain();
      check_eq("keep_out", bk_tkeep, 8'h0F);
      check_eq("user_out", bk_user, 4'hA);
      pulse_done();
      exp_frames++;
      tick();
      check_eq("stat_beats", stat_beats, exp_stat(n_start - base_start));
      check_eq("stat_frames", stat_frames, exp_stat(exp_frames));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
